tia_horizontal_counter: RTL and testbench
=========================================

Name: tia_horizontal_counter

Overview:
- Horizontal sync counter for the TIA. It is driven by the phi1/phi2 pulses from the biphase clock generator.
- It holds a 6-bit two-phase polynomial (LFSR) counter with 57 states per scanline: 57 steps x 4 clk = 228 clk per line.
- It decodes the line-timing signals hsync, cb (colour burst) and hblank, and an end-of-line strobe.
- The playfield, object and sync-output stages downstream consume these signals.

Parameters:
- LINE_STEPS, 57, number of counter steps per line; index wraps from LINE_STEPS-1 to 0.
- HBLANK_END, 16, index at which hblank clears on a normal line.
- HBLANK_END_LATE, 18, index at which hblank clears when hmove_late=1.

Ports:
- clk  in  1  system clock; the only clock. Every flop is clocked on its posedge.
- r  in  1  reset; synchronous, active-high.
- phi1  in  1  one-clk enable pulse from the biphase clock; master-latch phase.
- phi2  in  1  one-clk enable pulse from the biphase clock; slave-transfer phase.
- rsync  in  1  RSYNC register strobe; forces the line back to index 0.
- hmove_late  in  1  level input; extends hblank for an HMOVE line.
- hpoly  out  6  slave polynomial state.
- hidx  out  6  binary step index, 0..56 (debug/verification view).
- hsync  out  1  horizontal sync.
- cb  out  1  colour burst window.
- hblank  out  1  horizontal blank.
- eol  out  1  one-clk pulse when the line wraps.

Behaviour:
- Reset:
  - r=1 at a clk posedge sets: master m=000000, slave hpoly=000000, hidx=0, pend_rs=0.
  - Outputs after reset: hsync=0, cb=0, hblank=1, eol=0.
  - r has priority over phi1, phi2 and rsync in the same cycle.
  - Reset mid-line discards any pending step.
- Recurrence:
  - next(s) = {~(s[0]^s[1]), s[5:1]}.
  - Starting from 000000, the sequence is 000000 -> 100000 -> 110000 -> 111000 -> 111100 -> 111110 -> 011111 -> ...
  - The state 111111 is never reached.
- phi1 cycle (r=0):
  - If hidx==LINE_STEPS-1, or pend_rs=1, or rsync=1: m <= 000000 and mi <= 0.
  - Otherwise: m <= next(hpoly) and mi <= hidx+1.
  - mi is the master copy of the index.
  - pend_rs is cleared.
- phi2 cycle (r=0):
  - hpoly <= m and hidx <= mi.
  - All decodes update in this same edge, from the new index.
  - Outputs are therefore visible the clk after the phi2 pulse.
- rsync outside a phi1 cycle: sets pend_rs, which is consumed at the next phi1.
- Idempotence: a phi2 with no phi1 since the previous phi2 reloads the same master, so there is no advance.
- Coincident phases: phi1 and phi2 in the same cycle means phi2 is performed and phi1 is ignored.
- Decodes (registered, evaluated at phi2 on the new hidx):
  - hidx==0: hblank<=1, and eol pulses for that single clk if the wrap came from 56 or from rsync.
  - hidx==4: hsync<=1.
  - hidx==8: hsync<=0, cb<=1.
  - hidx==12: cb<=0.
  - hidx==HBLANK_END with hmove_late=0, or hidx==HBLANK_END_LATE with hmove_late=1: hblank<=0.
  - hmove_late is sampled at the phi2 edge of each step.
  - If hmove_late rises between index 16 and 17 after hblank has already cleared, hblank stays 0.
  - rsync mid-hsync or mid-cb: the wrap to 0 leaves hsync and cb at their current values until the next index 8/12 decode clears them.
  - Exception to the above: an rsync that lands at index 0..3 does not set hsync early.
- eol is 0 in every cycle except the phi2+1 clk of a wrap.

Test Plan:
- Release r, then drive the standard 4-clk biphase pattern (phi1, -, phi2, -) -> hpoly steps 000000, 100000, 110000, 111000, 111100 at the clk after each phi2; hidx steps 0..4.
- Full line of 228 clk -> hidx reaches 56, then wraps to 0 with hpoly=000000; exactly one eol pulse per 228 clk; 111111 never seen.
- Decode windows, hmove_late=0 -> hsync high for idx 4..7 (16 clk); cb high for idx 8..11; hblank low from idx 16 until the wrap.
- hmove_late=1 -> hblank clears at idx 18 instead of 16; hsync/cb timing unchanged.
- rsync pulse at idx 30 (non-phi1 clk) -> next phi1/phi2 gives hidx=0 and eol=1; the line restarts and hsync next rises at idx 4.
- r asserted at idx 10 while cb=1 -> next clk: hidx=0, hpoly=0, cb=0, hsync=0, hblank=1; a phi2 in the same cycle as r is ignored.

Source files
------------

// File: rtl/tia_horizontal_counter_if.sv
// Line-timing bus between the biphase clock generator / register strobes and the
// horizontal counter, plus the decoded line-timing outputs.
interface tia_horizontal_counter_if;
  logic       phi1;
  logic       phi2;
  logic       rsync;
  logic       hmove_late;
  logic [5:0] hpoly;
  logic [5:0] hidx;
  logic       hsync;
  logic       cb;
  logic       hblank;
  logic       eol;

  modport master (
    output phi1, phi2, rsync, hmove_late,
    input  hpoly, hidx, hsync, cb, hblank, eol
  );

  modport slave (
    input  phi1, phi2, rsync, hmove_late,
    output hpoly, hidx, hsync, cb, hblank, eol
  );
endinterface

// File: rtl/tia_horizontal_counter.sv
// TIA horizontal sync counter: two-phase 6-bit polynomial counter (57 steps per line)
// with registered hsync / colour-burst / hblank / end-of-line decodes.
module tia_horizontal_counter #(
  parameter int unsigned LINE_STEPS      = 57,
  parameter int unsigned HBLANK_END      = 16,
  parameter int unsigned HBLANK_END_LATE = 18
) (
  input logic                     clk,
  input logic                     r,
  tia_horizontal_counter_if.slave bus
);

  localparam logic [5:0] LastIdx      = 6'(LINE_STEPS - 1);
  localparam logic [5:0] HblankEnd    = 6'(HBLANK_END);
  localparam logic [5:0] HblankEndLat = 6'(HBLANK_END_LATE);
  localparam logic [5:0] HsyncSetIdx  = 6'd4;
  localparam logic [5:0] CbSetIdx     = 6'd8;
  localparam logic [5:0] CbClrIdx     = 6'd12;

  function automatic logic [5:0] poly_next(input logic [5:0] s);
    return {~(s[0] ^ s[1]), s[5:1]};
  endfunction

  logic [5:0] m_q, m_d;
  logic [5:0] mi_q, mi_d;
  logic [5:0] hpoly_q, hpoly_d;
  logic [5:0] hidx_q, hidx_d;
  logic       pend_q, pend_d;
  logic       wrap_q, wrap_d;
  logic       hsync_q, hsync_d;
  logic       cb_q, cb_d;
  logic       hblank_q, hblank_d;
  logic       eol_q, eol_d;

  logic do_phi1;
  logic do_phi2;
  logic wrap_now;
  logic hblank_clr;

  // A coincident phi1 is dropped so the slave transfer always wins.
  assign do_phi2  = bus.phi2;
  assign do_phi1  = bus.phi1 & ~bus.phi2;
  assign wrap_now = (hidx_q == LastIdx) | pend_q | bus.rsync;

  assign hblank_clr = bus.hmove_late ? (mi_q == HblankEndLat) : (mi_q == HblankEnd);

  always_comb begin
    m_d      = m_q;
    mi_d     = mi_q;
    hpoly_d  = hpoly_q;
    hidx_d   = hidx_q;
    pend_d   = pend_q;
    wrap_d   = wrap_q;
    hsync_d  = hsync_q;
    cb_d     = cb_q;
    hblank_d = hblank_q;
    eol_d    = 1'b0;

    if (do_phi1) begin
      if (wrap_now) begin
        m_d  = '0;
        mi_d = '0;
      end else begin
        m_d  = poly_next(hpoly_q);
        mi_d = hidx_q + 6'd1;
      end
      // wrap_q marks a genuine wrap so a repeated phi2 at index 0 gives no second eol.
      wrap_d = wrap_now;
      pend_d = 1'b0;
    end else if (bus.rsync) begin
      pend_d = 1'b1;
    end

    if (do_phi2) begin
      hpoly_d = m_q;
      hidx_d  = mi_q;
      wrap_d  = 1'b0;
      eol_d   = wrap_q;
      if (mi_q == '0) begin
        hblank_d = 1'b1;
      end
      if (mi_q == HsyncSetIdx) begin
        hsync_d = 1'b1;
      end
      if (mi_q == CbSetIdx) begin
        hsync_d = 1'b0;
        cb_d    = 1'b1;
      end
      if (mi_q == CbClrIdx) begin
        cb_d = 1'b0;
      end
      if (hblank_clr) begin
        hblank_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      m_q      <= '0;
      mi_q     <= '0;
      hpoly_q  <= '0;
      hidx_q   <= '0;
      pend_q   <= 1'b0;
      wrap_q   <= 1'b0;
      hsync_q  <= 1'b0;
      cb_q     <= 1'b0;
      hblank_q <= 1'b1;
      eol_q    <= 1'b0;
    end else begin
      m_q      <= m_d;
      mi_q     <= mi_d;
      hpoly_q  <= hpoly_d;
      hidx_q   <= hidx_d;
      pend_q   <= pend_d;
      wrap_q   <= wrap_d;
      hsync_q  <= hsync_d;
      cb_q     <= cb_d;
      hblank_q <= hblank_d;
      eol_q    <= eol_d;
    end
  end

  assign bus.hpoly  = hpoly_q;
  assign bus.hidx   = hidx_q;
  assign bus.hsync  = hsync_q;
  assign bus.cb     = cb_q;
  assign bus.hblank = hblank_q;
  assign bus.eol    = eol_q;

endmodule

// File: tb/tb_tia_horizontal_counter.sv
// Self-checking bench for tia_horizontal_counter: directed line-timing scenarios plus
// randomized phase/rsync/reset stimulus against a step-level reference model.
module tb_tia_horizontal_counter;

  logic clk = 1'b0;
  logic r;

  tia_horizontal_counter_if bus ();

  tia_horizontal_counter #(
    .LINE_STEPS     (57),
    .HBLANK_END     (16),
    .HBLANK_END_LATE(18)
  ) dut (
    .clk(clk),
    .r  (r),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ph       = 0;

  // Reference model state: line index, master index, pending rsync, decoded outputs.
  int e_idx, e_midx;
  bit e_pend, e_mwrap, e_hsync, e_cb, e_hblank, e_eol;

  function automatic logic [5:0] poly_of(input int n);
    logic [5:0] s;
    s = '0;
    for (int k = 0; k < n; k++) s = {~(s[0] ^ s[1]), s[5:1]};
    return s;
  endfunction

  function automatic void model(input bit p1, input bit p2, input bit rs, input bit hml,
                                input bit rr);
    if (rr) begin
      e_idx = 0; e_midx = 0; e_pend = 0; e_mwrap = 0;
      e_hsync = 0; e_cb = 0; e_hblank = 1; e_eol = 0;
      return;
    end
    e_eol = 0;
    if (p2) begin
      e_idx = e_midx;
      if (e_idx == 0) begin
        e_hblank = 1;
        e_eol    = e_mwrap;
      end
      if (e_idx == 4) e_hsync = 1;
      if (e_idx == 8) begin
        e_hsync = 0;
        e_cb    = 1;
      end
      if (e_idx == 12) e_cb = 0;
      if (e_idx == (hml ? 18 : 16)) e_hblank = 0;
      e_mwrap = 0;
      if (rs) e_pend = 1;
    end else if (p1) begin
      e_mwrap = (e_idx == 56) || e_pend || rs;
      e_midx  = e_mwrap ? 0 : e_idx + 1;
      e_pend  = 0;
    end else if (rs) begin
      e_pend = 1;
    end
  endfunction

  task automatic tick(input bit p1, input bit p2, input bit rs, input bit hml, input bit rr);
    @(negedge clk);
    bus.phi1       = p1;
    bus.phi2       = p2;
    bus.rsync      = rs;
    bus.hmove_late = hml;
    r              = rr;
    @(posedge clk);
    model(p1, p2, rs, hml, rr);
    #1;
  endtask

  task automatic run_tick(input bit rs, input bit hml);
    tick(ph % 4 == 0, ph % 4 == 2, rs, hml, 1'b0);
    ph++;
  endtask

  task automatic step(input bit hml);
    repeat (4) run_tick(1'b0, hml);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ph = 0;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ph = 0;
    n_checks++;
    if (bus.hidx !== 6'd0) begin
      n_fail++; $display("FAIL reset_hidx: got %0d expected 0", bus.hidx);
    end
    n_checks++;
    if (bus.hpoly !== 6'b000000) begin
      n_fail++; $display("FAIL reset_hpoly: got %b expected 000000", bus.hpoly);
    end
    n_checks++;
    if ({bus.hsync, bus.cb, bus.hblank, bus.eol} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_decodes: got hsync/cb/hblank/eol=%b expected 0010",
               {bus.hsync, bus.cb, bus.hblank, bus.eol});
    end
  endtask

  task automatic test_sequence();
    logic [5:0] exp_seq [7];
    exp_seq = '{6'b000000, 6'b100000, 6'b110000, 6'b111000, 6'b111100, 6'b111110,
                6'b011111};
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      run_tick(1'b0, 1'b0);
      n_checks++;
      if (bus.hidx !== 6'(k - 1)) begin
        n_fail++; $display("FAIL seq_phi1_hold: got %0d expected %0d", bus.hidx, k - 1);
      end
      run_tick(1'b0, 1'b0);
      run_tick(1'b0, 1'b0);
      n_checks++;
      if (bus.hpoly !== exp_seq[k] || bus.hidx !== 6'(k)) begin
        n_fail++;
        $display("FAIL seq_step%0d: got hpoly=%b hidx=%0d expected hpoly=%b hidx=%0d", k,
                 bus.hpoly, bus.hidx, exp_seq[k], k);
      end
      run_tick(1'b0, 1'b0);
    end
    // Lone phi2, then coincident phi1+phi2: neither may advance.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.hidx !== 6'd5) begin
      n_fail++; $display("FAIL idempotent_phi2: got %0d expected 5", bus.hidx);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.hidx !== 6'd5 || bus.hpoly !== exp_seq[5]) begin
      n_fail++;
      $display("FAIL coincident_phases: got hidx=%0d hpoly=%b expected 5 %b", bus.hidx,
               bus.hpoly, exp_seq[5]);
    end
    ph = 0;
    step(1'b0);
    n_checks++;
    if (bus.hpoly !== exp_seq[6] || bus.hidx !== 6'd6) begin
      n_fail++;
      $display("FAIL seq_step6: got hpoly=%b hidx=%0d expected %b 6", bus.hpoly, bus.hidx,
               exp_seq[6]);
    end
  endtask

  task automatic test_full_line();
    int eol_cnt, hs_cnt, cb_cnt, hb_lo, max_idx;
    bit saw_ff;
    do_reset();
    eol_cnt = 0; max_idx = 0; saw_ff = 0;
    for (int i = 0; i < 57 * 4; i++) begin
      run_tick(1'b0, 1'b0);
      if (bus.eol) eol_cnt++;
      if (bus.hpoly == 6'h3f) saw_ff = 1;
      if (int'(bus.hidx) > max_idx) max_idx = int'(bus.hidx);
    end
    n_checks++;
    if (max_idx != 56 || bus.hidx !== 6'd0 || bus.hpoly !== 6'd0) begin
      n_fail++;
      $display("FAIL line_wrap: got max_idx=%0d hidx=%0d hpoly=%b expected 56 0 000000",
               max_idx, bus.hidx, bus.hpoly);
    end
    n_checks++;
    if (eol_cnt != 1) begin
      n_fail++; $display("FAIL line1_eol_count: got %0d expected 1", eol_cnt);
    end
    eol_cnt = 0; hs_cnt = 0; cb_cnt = 0; hb_lo = 0;
    for (int i = 0; i < 57 * 4; i++) begin
      run_tick(1'b0, 1'b0);
      if (bus.eol) eol_cnt++;
      if (bus.hsync) hs_cnt++;
      if (bus.cb) cb_cnt++;
      if (!bus.hblank) hb_lo++;
      if (bus.hpoly == 6'h3f) saw_ff = 1;
    end
    n_checks++;
    if (eol_cnt != 1 || hs_cnt != 16 || cb_cnt != 16 || hb_lo != 164) begin
      n_fail++;
      $display("FAIL line_windows: got eol=%0d hsync=%0d cb=%0d hblank_lo=%0d expected 1 16 16 164",
               eol_cnt, hs_cnt, cb_cnt, hb_lo);
    end
    n_checks++;
    if (saw_ff) begin
      n_fail++; $display("FAIL poly_111111_seen: got 1 expected 0");
    end
  endtask

  task automatic test_hmove_late();
    int hb_fall, hs_rise, cb_rise;
    do_reset();
    hb_fall = -1; hs_rise = -1; cb_rise = -1;
    for (int i = 0; i < 57 * 4; i++) begin
      run_tick(1'b0, 1'b1);
      if (hb_fall < 0 && !bus.hblank) hb_fall = int'(bus.hidx);
      if (hs_rise < 0 && bus.hsync) hs_rise = int'(bus.hidx);
      if (cb_rise < 0 && bus.cb) cb_rise = int'(bus.hidx);
    end
    n_checks++;
    if (hb_fall != 18) begin
      n_fail++; $display("FAIL hmove_hblank_end: got %0d expected 18", hb_fall);
    end
    n_checks++;
    if (hs_rise != 4 || cb_rise != 8) begin
      n_fail++;
      $display("FAIL hmove_sync_timing: got hsync@%0d cb@%0d expected 4 8", hs_rise, cb_rise);
    end
    // hmove_late rising after hblank already cleared must not re-raise it.
    do_reset();
    repeat (16) step(1'b0);
    repeat (4) step(1'b1);
    n_checks++;
    if (bus.hblank !== 1'b0 || bus.hidx !== 6'd20) begin
      n_fail++;
      $display("FAIL hmove_late_rise: got hblank=%b hidx=%0d expected 0 20", bus.hblank,
               bus.hidx);
    end
  endtask

  task automatic test_rsync();
    do_reset();
    repeat (29) step(1'b0);
    repeat (3) run_tick(1'b0, 1'b0);
    n_checks++;
    if (bus.hidx !== 6'd30) begin
      n_fail++; $display("FAIL rsync_setup: got %0d expected 30", bus.hidx);
    end
    run_tick(1'b1, 1'b0);
    repeat (3) run_tick(1'b0, 1'b0);
    n_checks++;
    if (bus.hidx !== 6'd0 || bus.hpoly !== 6'd0 || bus.eol !== 1'b1 || bus.hblank !== 1'b1)
    begin
      n_fail++;
      $display("FAIL rsync_wrap: got hidx=%0d hpoly=%b eol=%b hblank=%b expected 0 0 1 1",
               bus.hidx, bus.hpoly, bus.eol, bus.hblank);
    end
    run_tick(1'b0, 1'b0);
    repeat (3) step(1'b0);
    n_checks++;
    if (bus.hsync !== 1'b0 || bus.hidx !== 6'd3) begin
      n_fail++;
      $display("FAIL rsync_hsync_idx3: got hsync=%b hidx=%0d expected 0 3", bus.hsync, bus.hidx);
    end
    step(1'b0);
    n_checks++;
    if (bus.hsync !== 1'b1 || bus.hidx !== 6'd4) begin
      n_fail++;
      $display("FAIL rsync_hsync_idx4: got hsync=%b hidx=%0d expected 1 4", bus.hsync, bus.hidx);
    end
    // rsync coincident with phi1 mid-hsync: wrap immediately, hsync held.
    step(1'b0);
    run_tick(1'b1, 1'b0);
    repeat (2) run_tick(1'b0, 1'b0);
    n_checks++;
    if (bus.hidx !== 6'd0 || bus.eol !== 1'b1 || bus.hsync !== 1'b1) begin
      n_fail++;
      $display("FAIL rsync_mid_hsync: got hidx=%0d eol=%b hsync=%b expected 0 1 1", bus.hidx,
               bus.eol, bus.hsync);
    end
    run_tick(1'b0, 1'b0);
    repeat (8) step(1'b0);
    n_checks++;
    if (bus.hsync !== 1'b0 || bus.cb !== 1'b1 || bus.hidx !== 6'd8) begin
      n_fail++;
      $display("FAIL rsync_idx8_decode: got hsync=%b cb=%b hidx=%0d expected 0 1 8", bus.hsync,
               bus.cb, bus.hidx);
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    repeat (10) step(1'b0);
    n_checks++;
    if (bus.cb !== 1'b1 || bus.hidx !== 6'd10) begin
      n_fail++;
      $display("FAIL midline_setup: got cb=%b hidx=%0d expected 1 10", bus.cb, bus.hidx);
    end
    run_tick(1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({bus.hidx, bus.hpoly, bus.hsync, bus.cb, bus.hblank, bus.eol} !== {12'd0, 4'b0010})
    begin
      n_fail++;
      $display("FAIL midline_reset: got hidx=%0d hpoly=%b hs/cb/hb/eol=%b expected 0 0 0010",
               bus.hidx, bus.hpoly, {bus.hsync, bus.cb, bus.hblank, bus.eol});
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.hidx !== 6'd0 || bus.eol !== 1'b0) begin
      n_fail++;
      $display("FAIL midline_discard: got hidx=%0d eol=%b expected 0 0", bus.hidx, bus.eol);
    end
    ph = 0;
  endtask

  task automatic test_random();
    bit p1, p2, rs, hml, rr;
    logic [17:0] got, exp;
    do_reset();
    hml = 0;
    for (int t = 0; t < 4000; t++) begin
      p1  = (t % 4 == 0) ^ ($urandom_range(0, 15) == 0);
      p2  = (t % 4 == 2) ^ ($urandom_range(0, 15) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      rr  = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 49) == 0) hml = ~hml;
      tick(p1, p2, rs, hml, rr);
      got = {bus.hpoly, bus.hidx, bus.hsync, bus.cb, bus.hblank, bus.eol, 2'b00};
      exp = {poly_of(e_idx), 6'(e_idx), e_hsync, e_cb, e_hblank, e_eol, 2'b00};
      n_checks++;
      if (got !== exp || bus.hpoly === 6'h3f) begin
        n_fail++;
        $display("FAIL random_t%0d: got poly/idx/hs/cb/hb/eol=%b/%0d/%b%b%b%b expected %b/%0d/%b%b%b%b",
                 t, bus.hpoly, bus.hidx, bus.hsync, bus.cb, bus.hblank, bus.eol,
                 poly_of(e_idx), e_idx, e_hsync, e_cb, e_hblank, e_eol);
      end
    end
  endtask

  initial begin
    r              = 1'b1;
    bus.phi1       = 1'b0;
    bus.phi2       = 1'b0;
    bus.rsync      = 1'b0;
    bus.hmove_late = 1'b0;
    test_reset();
    test_sequence();
    test_full_line();
    test_hmove_late();
    test_rsync();
    test_reset_midline();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
